seg_scan_arb: RTL and testbench

SEG_SCAN_ARB -- requirements
Module: seg_scan_arb

---
 rtl/seg_pkg.sv | 24 ++
 rtl/bcd_to_seg.sv | 26 ++
 rtl/seg_scan_arb.sv | 145 ++++++++++++++
 tb/tb_seg_scan_arb.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 6-digit seven-segment scanner:
// digit count, segment patterns (bit6 = a ... bit0 = g) and arbiter states.
package seg_pkg;

   localparam int unsigned NUM_DIGITS = 6;

   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   typedef enum logic {
      SRC0 = 1'b0,
      SRC1 = 1'b1
   } arb_state_e;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-high seven-segment decoder; codes 10-15 blank.
module bcd_to_seg
   import seg_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      case (i_bcd)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_scan_arb.sv
// Six-digit seven-segment scanner with a frame-aligned two-source arbiter
// (src1 overlay with minimum hold) and per-digit blink masking.
module seg_scan_arb
   import seg_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned BLINK_FRAMES = 250,
   parameter int unsigned OVL_HOLD     = 500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] i_src0_bcd,
   input  logic [5:0]  i_src0_dp,
   input  logic        i_src1_req,
   input  logic [23:0] i_src1_bcd,
   input  logic [5:0]  i_src1_dp,
   input  logic [5:0]  i_blink_mask,
   output logic        o_src1_gnt,
   output logic [5:0]  o_seg_enb,
   output logic [6:0]  o_seg,
   output logic        o_seg_dp,
   output logic        o_frame
);

   localparam int unsigned PW = $clog2(SCAN_DIV);
   localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int unsigned HW = $clog2(OVL_HOLD + 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [2:0]    idx_q, idx_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_q, blink_d;
   logic [HW-1:0] hold_q, hold_inc;
   arb_state_e    state_q;
   logic          gnt_q, frame_q;
   logic          slot_tick, frame_end;

   logic [23:0]   sel_bcd;
   logic [5:0]    sel_dp;
   logic [3:0]    code;
   logic [6:0]    seg_dec;
   logic          blank;
   logic [5:0]    enb_d, enb_q;
   logic [6:0]    seg_d, seg_q;
   logic          dp_d, dp_q;

   always_comb begin
      slot_tick   = (presc_q == PW'(SCAN_DIV - 1));
      frame_end   = slot_tick && (idx_q == 3'(NUM_DIGITS - 1));
      presc_d     = slot_tick ? '0 : presc_q + PW'(1);
      idx_d       = idx_q;
      if (slot_tick) idx_d = frame_end ? '0 : idx_q + 3'd1;
      blink_cnt_d = blink_cnt_q;
      blink_d     = blink_q;
      if (frame_end) begin
         if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
         end
      end
      hold_inc = (hold_q == HW'(OVL_HOLD)) ? hold_q : hold_q + HW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q     <= '0;
         idx_q       <= '0;
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         idx_q       <= idx_d;
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
      end
   end

   // The hold count includes the frame ending now, so release happens on the
   // OVL_HOLD-th frame boundary after the grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SRC0;
         hold_q  <= '0;
         gnt_q   <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         frame_q <= frame_end;
         if (frame_end) begin
            case (state_q)
               SRC0: begin
                  if (i_src1_req) begin
                     state_q <= SRC1;
                     gnt_q   <= 1'b1;
                     hold_q  <= '0;
                  end
               end
               SRC1: begin
                  hold_q <= hold_inc;
                  if (!i_src1_req && (hold_inc == HW'(OVL_HOLD))) begin
                     state_q <= SRC0;
                     gnt_q   <= 1'b0;
                  end
               end
               default: state_q <= SRC0;
            endcase
         end
      end
   end

   always_comb begin
      sel_bcd = (state_q == SRC1) ? i_src1_bcd : i_src0_bcd;
      sel_dp  = (state_q == SRC1) ? i_src1_dp  : i_src0_dp;
      code    = 4'(sel_bcd >> {idx_q, 2'b00});
      blank   = blink_q && i_blink_mask[idx_q];
      enb_d   = blank ? '1 : ~(6'b000001 << idx_q);
      seg_d   = blank ? '0 : seg_dec;
      dp_d    = !blank && sel_dp[idx_q];
   end

   bcd_to_seg u_dec (
      .i_bcd (code),
      .o_seg (seg_dec)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         enb_q <= '1;
         seg_q <= '0;
         dp_q  <= 1'b0;
      end else begin
         enb_q <= enb_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign o_seg_enb  = enb_q;
   assign o_seg      = seg_q;
   assign o_seg_dp   = dp_q;
   assign o_frame    = frame_q;
   assign o_src1_gnt = gnt_q;

endmodule

// File: tb/tb_seg_scan_arb.sv
// Randomized bench for seg_scan_arb against a cycle-count based reference model.
module tb_seg_scan_arb;

   localparam int SD = 4;
   localparam int BF = 2;
   localparam int OH = 3;
   localparam int FC = 6 * SD;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] src0_bcd, src1_bcd;
   logic [5:0]  src0_dp, src1_dp, blink_mask;
   logic        src1_req;
   logic        src1_gnt, seg_dp, frame;
   logic [5:0]  seg_enb;
   logic [6:0]  seg;

   int n_tests = 0;
   int n_fail  = 0;

   // model: edges since reset, grant flag, frames shown under src1
   int e      = 0;
   bit gnt_m  = 1'b0;
   int shown  = 0;

   logic [6:0] seg_tbl [10];

   always #5 clk = ~clk;

   seg_scan_arb #(
      .SCAN_DIV     (SD),
      .BLINK_FRAMES (BF),
      .OVL_HOLD     (OH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_src0_bcd   (src0_bcd),
      .i_src0_dp    (src0_dp),
      .i_src1_req   (src1_req),
      .i_src1_bcd   (src1_bcd),
      .i_src1_dp    (src1_dp),
      .i_blink_mask (blink_mask),
      .o_src1_gnt   (src1_gnt),
      .o_seg_enb    (seg_enb),
      .o_seg        (seg),
      .o_seg_dp     (seg_dp),
      .o_frame      (frame)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @e=%0d: got %0h, expected %0h", tag, e, got, exp);
      end
   endtask

   // Predicts outputs after the coming edge from the currently driven inputs,
   // then checks them on the following falling edge.
   task automatic step();
      logic [5:0]  x_enb;
      logic [6:0]  x_seg;
      logic        x_dp, x_frame;
      logic [23:0] bcd;
      logic [5:0]  dpv;
      int          dig, ph, code;
      if (rst) begin
         x_enb = 6'h3f; x_seg = 7'h0; x_dp = 1'b0; x_frame = 1'b0;
         e = 0; gnt_m = 1'b0; shown = 0;
      end else begin
         dig = (e / SD) % 6;
         ph  = ((e / FC) / BF) % 2;
         bcd = gnt_m ? src1_bcd : src0_bcd;
         dpv = gnt_m ? src1_dp  : src0_dp;
         if (ph == 1 && blink_mask[dig]) begin
            x_enb = 6'h3f; x_seg = 7'h0; x_dp = 1'b0;
         end else begin
            x_enb = 6'h3f & ~(6'(1) << dig);
            code  = int'((bcd >> (4 * dig)) & 24'hf);
            x_seg = (code < 10) ? seg_tbl[code] : 7'h0;
            x_dp  = dpv[dig];
         end
         x_frame = ((e + 1) % FC) == 0;
         if (x_frame) begin
            if (!gnt_m) begin
               if (src1_req) begin gnt_m = 1'b1; shown = 0; end
            end else begin
               shown++;
               if (!src1_req && shown >= OH) gnt_m = 1'b0;
            end
         end
         e++;
      end
      @(negedge clk);
      check_eq("seg_enb", 32'(seg_enb), 32'(x_enb));
      check_eq("seg",     32'(seg),     32'(x_seg));
      check_eq("seg_dp",  32'(seg_dp),  32'(x_dp));
      check_eq("frame",   32'(frame),   32'(x_frame));
      check_eq("gnt",     32'(src1_gnt), 32'(gnt_m));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      seg_tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                  7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
      rst = 1'b1; src0_bcd = 24'h123456; src0_dp = '0; src1_req = 1'b0;
      src1_bcd = 24'h999999; src1_dp = '0; blink_mask = '0;
      @(negedge clk);
      run(2);
      rst = 1'b0;
      run(2 * FC);

      // overlay request raised mid-frame, held one frame after grant, dropped
      while (e % FC != 10) step();
      src1_req = 1'b1;
      while (!gnt_m) step();
      check_eq("gnt_on_frame", 32'(frame), 32'd1);
      run(FC);
      src1_req = 1'b0;
      run(4 * FC);

      // blink on digit 0, invalid code, decimal points
      blink_mask = 6'b000001;
      src0_dp    = 6'b100101;
      run(5 * FC);
      src0_bcd   = 24'h12345a;
      blink_mask = '0;
      run(2 * FC);

      // reset while src1 owns the display
      src1_req = 1'b1;
      while (!gnt_m) step();
      run(30);
      rst = 1'b1;
      step();
      check_eq("rst_gnt", 32'(src1_gnt), 32'd0);
      check_eq("rst_enb", 32'(seg_enb), 32'h3f);
      rst = 1'b0; src1_req = 1'b0;
      step();
      check_eq("restart_digit0", 32'(seg_enb), 32'h3e);
      run(FC);

      // randomized traffic
      for (int i = 0; i < 6000; i++) begin
         src0_bcd = 24'($urandom);
         src1_bcd = 24'($urandom);
         src0_dp  = 6'($urandom);
         src1_dp  = 6'($urandom);
         if ($urandom_range(0, 39) == 0) src1_req = ~src1_req;
         if ($urandom_range(0, 199) == 0) blink_mask = 6'($urandom);
         rst = ($urandom_range(0, 1499) == 0);
         step();
      end
      rst = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
